gate_bist_driver: RTL and testbench

GATE_BIST_DRIVER -- requirements
Module: gate_bist_driver

---
 rtl/gate_bist_driver.sv | 108 ++++++++++
 tb/tb_gate_bist_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_driver.sv
// rtl/gate_bist_driver.sv - BIST pattern driver with LFSR stimulus and MISR response compaction
// Optional golden compare is enabled by defining BIST_COMPARE_EN.
module gate_bist_driver #(
    parameter int PAT_W = 14,
    parameter int RSP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      pattern_count,
    output logic [PAT_W-1:0] pat_o,
    input  logic [RSP_W-1:0] rsp_i,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
`ifdef BIST_COMPARE_EN
    input  logic [15:0]      golden,
`endif
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PAT_W-1:0] lfsr;
    logic [PAT_W-1:0] lfsr_next;
    logic [15:0]      misr;
    logic [15:0]      misr_next;
    logic [15:0]      count;
    logic             accept;
    logic             last_pattern;

    assign accept       = (state == IDLE) && start;
    assign last_pattern = (count == 16'd1);

    assign lfsr_next = {lfsr[PAT_W-2:0], lfsr[13] ^ lfsr[12] ^ lfsr[11] ^ lfsr[1]};
    assign misr_next = {misr[14:0], misr[15] ^ misr[14] ^ misr[12] ^ misr[3]} ^ 16'(rsp_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (pattern_count == 16'd0) ? DONE : APPLY;
            APPLY:   state_next = CAPTURE;
            CAPTURE: state_next = last_pattern ? DONE : APPLY;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == APPLY) || (state == CAPTURE);
        done  = (state == DONE);
        pat_o = busy ? lfsr : '0;
    end

    // Response is sampled on the edge that ends CAPTURE, so the pattern has settled for two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= PAT_W'(1);
            misr  <= 16'h0000;
            count <= 16'h0000;
        end else if (accept) begin
            lfsr  <= PAT_W'(1);
            misr  <= 16'h0000;
            count <= pattern_count;
        end else if (state == CAPTURE) begin
            lfsr  <= lfsr_next;
            misr  <= misr_next;
            count <= count - 16'd1;
        end
    end

    assign signature = misr;

`ifdef BIST_COMPARE_EN
    logic pass_q;

    // Compare against the value the MISR takes on entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else if (accept) begin
            pass_q <= (pattern_count == 16'd0) && (golden == 16'h0000);
        end else if ((state == CAPTURE) && last_pattern) begin
            pass_q <= (misr_next == golden);
        end
    end

    assign pass = pass_q;
`else
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_gate_bist_driver.sv
// tb/tb_gate_bist_driver.sv - self-checking bench for gate_bist_driver (optionally BIST_COMPARE_EN)
module tb_gate_bist_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pattern_count;
    logic [13:0] pat_o;
    logic [9:0]  rsp_i;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [15:0] golden;
    logic        pass;

    int   checks   = 0;
    int   failures = 0;
    bit   hold_en;
    logic [9:0] hold_val;
    logic [9:0] mask;

    gate_bist_driver #(.PAT_W(14), .RSP_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pattern_count(pattern_count),
        .pat_o        (pat_o),
        .rsp_i        (rsp_i),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
`ifdef BIST_COMPARE_EN
        .golden       (golden),
`endif
        .pass         (pass)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] gate_fn(input logic [13:0] p, input logic [9:0] m);
        return p[9:0] ^ {p[13:10], p[13:8]} ^ m;
    endfunction

    always_comb rsp_i = hold_en ? hold_val : gate_fn(pat_o, mask);

    function automatic logic [13:0] lfsr_step(input logic [13:0] v);
        int fb;
        fb = ((v >> 13) ^ (v >> 12) ^ (v >> 11) ^ (v >> 1)) & 1;
        return 14'(((int'(v) * 2) & 16'h3FFF) + fb);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] r);
        int fb;
        fb = ((s >> 15) ^ (s >> 14) ^ (s >> 12) ^ (s >> 3)) & 1;
        return 16'(((int'(s) * 2) & 16'hFFFF) + fb) ^ {6'b0, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input int n, input int rst_at, input bit repulse,
                       input bit match_golden, input logic [15:0] exp_const, input bit use_const);
        logic [13:0] pats[$];
        logic [13:0] lf;
        logic [15:0] s;
        logic [15:0] exp_sig;
        logic        exp_pass;
        logic        eb;
        logic [13:0] ep;
        bit          idle_after;
        int          exp_dones;
        int          errs_busy, errs_pat, errs_idle, dones, done_at;
        lf = 14'h0001;
        s  = 16'h0000;
        for (int i = 0; i < n; i++) begin
            pats.push_back(lf);
            s  = misr_step(s, hold_en ? hold_val : gate_fn(lf, mask));
            lf = lfsr_step(lf);
        end
        if (match_golden) golden = s;
        exp_sig   = (rst_at > 0) ? 16'h0000 : s;
        exp_dones = (rst_at > 0) ? 0 : 1;
`ifdef BIST_COMPARE_EN
        exp_pass  = (rst_at == 0) && (exp_sig == golden);
`else
        exp_pass  = 1'b0;
`endif
        errs_busy = 0; errs_pat = 0; errs_idle = 0; dones = 0; done_at = -1;
        @(negedge clk);
        start = 1'b1;
        pattern_count = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        pattern_count = 16'($urandom);
        for (int c = 1; c <= 2 * n + 4; c++) begin
            @(negedge clk);
            idle_after = (rst_at > 0) && (c > rst_at);
            eb = !idle_after && (c <= 2 * n);
            ep = eb ? pats[(c - 1) / 2] : 14'h0000;
            if (busy !== eb) errs_busy++;
            if (pat_o !== ep) errs_pat++;
            if (done === 1'b1) begin
                dones++;
                done_at = c;
            end
            if (idle_after && (signature !== 16'h0000 || pass !== 1'b0)) errs_idle++;
            start = repulse && (c == 2);
            rst   = (rst_at == c);
        end
        start = 1'b0;
        rst   = 1'b0;
        check({tag, "_busy_errs"}, errs_busy, 0);
        check({tag, "_pat_errs"}, errs_pat, 0);
        check({tag, "_idle_errs"}, errs_idle, 0);
        check({tag, "_done_count"}, dones, exp_dones);
        check({tag, "_done_cycle"}, done_at, (exp_dones == 1) ? 2 * n + 1 : -1);
        check({tag, "_signature"}, signature, exp_sig);
        check({tag, "_pass"}, pass, exp_pass);
        if (use_const) check({tag, "_sig_const"}, signature, exp_const);
    endtask

    initial begin
        int errs;
        rst = 1'b1;
        start = 1'b0;
        pattern_count = 16'd0;
        golden = 16'h0000;
        hold_en = 1'b1;
        hold_val = 10'h3FF;
        mask = 10'h000;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pat", pat_o, 0);
        check("reset_sig", signature, 0);
        check("reset_pass", pass, 0);
        rst = 1'b0;

        run("n1", 1, 0, 0, 0, 16'h03FF, 1);
        golden = 16'h0400;
        run("n2", 2, 0, 0, 0, 16'h0400, 1);
        run("n0", 0, 0, 0, 0, 16'h0000, 1);
        run("repulse", 3, 0, 1, 0, 16'h0000, 0);
        run("rst_mid", 5, 3, 0, 0, 16'h0000, 1);
        run("after_rst", 4, 0, 0, 0, 16'h0000, 0);
        golden = 16'h1234;
        run("mismatch", 2, 0, 0, 0, 16'h0400, 1);

        errs = 0;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        pattern_count = 16'd3;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) errs++;
        end
        check("rst_wins_start", errs, 0);

        hold_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mask = 10'($urandom);
            golden = 16'($urandom);
            run("rand", int'($urandom_range(1, 60)), 0, 0, ($urandom % 2) == 1, 16'h0000, 0);
        end
        mask = 10'($urandom);
        run("long", 700, 0, 0, 1, 16'h0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
